// File: rtl/cv32e40s_sleep_ctrl.sv
// Sleep controller: drives the core clock-gate enable on the ungated clock.
// Holds the core off until boot, gates it after a drained WFI, and restarts it on wake.
module cv32e40s_sleep_ctrl #(
    parameter int unsigned SLEEP_DELAY = 2,   // consecutive idle DRAIN cycles before gating (1..15)
    parameter int unsigned WAKE_CYCLES = 1    // clock-running cycles in WAKE before release (1..7)
) (
    input  logic clk_ungated_i,
    input  logic rst_ni,
    input  logic fetch_enable_i,
    input  logic wfi_req_i,
    input  logic pipe_idle_i,
    input  logic lsu_busy_i,
    input  logic wake_irq_i,
    input  logic debug_req_i,
    output logic clk_gate_en_o,
    output logic core_sleep_o,
    output logic wake_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(SLEEP_DELAY - 1);
    localparam logic [CNT_W-1:0] WAKE_END  = CNT_W'(WAKE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_SLEEP = 3'd3,
        S_WAKE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fe_q, fe_d;
    logic             en_q, en_d;
    logic             sleep_q, sleep_d;
    logic             wake_q, wake_d;

    logic             wake_c;
    logic             idle_c;
    logic [CNT_W-1:0] cnt_inc_c;

    assign wake_c    = wake_irq_i | debug_req_i;
    assign idle_c    = pipe_idle_i & ~lsu_busy_i;
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fe_d    = fe_q | fetch_enable_i;
        en_d    = 1'b0;
        sleep_d = 1'b1;
        wake_d  = 1'b0;

        case (state_q)
            S_BOOT: begin
                // Boot permission is sticky; wake and WFI are ignored here
                if (fetch_enable_i || fe_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wfi_req_i && !wake_c) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (wake_c || !wfi_req_i) begin
                    state_d = S_RUN;
                end else if (!idle_c) begin
                    cnt_d = '0;
                end else if (cnt_q == DRAIN_END) begin
                    state_d = S_SLEEP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            S_SLEEP: begin
                if (wake_c) begin
                    state_d = S_WAKE;
                    cnt_d   = '0;
                end
            end
            S_WAKE: begin
                // Once started, wake always completes even if the request drops
                if (cnt_q == WAKE_END) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    wake_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d = S_BOOT;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            S_RUN, S_DRAIN: begin
                en_d    = 1'b1;
                sleep_d = 1'b0;
            end
            S_WAKE: begin
                en_d    = 1'b1;
                sleep_d = 1'b1;
            end
            default: begin
                en_d    = 1'b0;
                sleep_d = 1'b1;
            end
        endcase
    end

    // State, counter and output flops; reset drops the gate enable immediately
    always_ff @(posedge clk_ungated_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_BOOT;
            cnt_q   <= '0;
            fe_q    <= 1'b0;
            en_q    <= 1'b0;
            sleep_q <= 1'b1;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fe_q    <= fe_d;
            en_q    <= en_d;
            sleep_q <= sleep_d;
            wake_q  <= wake_d;
        end
    end

    assign clk_gate_en_o = en_q;
    assign core_sleep_o  = sleep_q;
    assign wake_o        = wake_q;

endmodule
